// File: rtl/uart_angle_cmd_pkg.sv
// Shared constants and types for the UART angle command parser. servo_control
// imports the same timing constants so both blocks agree on pulse widths.
package uart_angle_cmd_pkg;

    // ASCII characters recognised by the parser
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;

    // Servo timing in 27 MHz clock counts
    localparam int unsigned CLK_PERIOD_NS = 37;
    localparam int unsigned PULSE_MIN     = 8108;   // 300 us
    localparam int unsigned PULSE_STEP    = 330;    // per degree
    localparam int unsigned PULSE_MAX     = 67567;  // 2500 us

    // Decimal accumulator width (holds up to 999)
    localparam int unsigned ACC_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StCalc,
        StDiscard
    } state_e;

    typedef enum logic [1:0] {
        ByteNone,
        ByteDigit,
        ByteTerm,
        ByteOther
    } byte_class_e;

    // Classify the byte on the receive interface; ByteNone when no strobe.
    function automatic byte_class_e classify_byte(input logic valid, input logic [7:0] b);
        if (!valid) begin
            return ByteNone;
        end else if (b >= CHAR_0 && b <= CHAR_9) begin
            return ByteDigit;
        end else if (b == CHAR_CR || b == CHAR_LF) begin
            return ByteTerm;
        end else begin
            return ByteOther;
        end
    endfunction

endpackage

// File: rtl/uart_angle_cmd_angle_to_width.sv
// Combinational angle-to-pulse-width conversion with upper saturation.
// The parent registers the result in its CALC state.
module angle_to_width
    import uart_angle_cmd_pkg::*;
#(
    parameter int unsigned PULSE_MIN  = uart_angle_cmd_pkg::PULSE_MIN,
    parameter int unsigned PULSE_STEP = uart_angle_cmd_pkg::PULSE_STEP,
    parameter int unsigned PULSE_MAX  = uart_angle_cmd_pkg::PULSE_MAX
) (
    input  logic [ACC_W-1:0] angle,
    output logic [31:0]      width
);

    logic [31:0] raw_width;

    // width = MIN + angle*STEP, clamped to MAX
    always_comb begin
        raw_width = 32'(angle) * PULSE_STEP + PULSE_MIN;
        width     = (raw_width > PULSE_MAX) ? PULSE_MAX : raw_width;
    end

endmodule

// File: rtl/uart_angle_cmd.sv
// Parses ASCII decimal angle commands terminated by CR or LF and converts a
// legal angle into a servo pulse width held on pwm_width.
module uart_angle_cmd
#(
    parameter int unsigned MAX_DIGITS  = 3,
    parameter int unsigned MAX_ANGLE   = 180,
    parameter int unsigned PULSE_MIN   = uart_angle_cmd_pkg::PULSE_MIN,
    parameter int unsigned PULSE_STEP  = uart_angle_cmd_pkg::PULSE_STEP,
    parameter int unsigned PULSE_MAX   = uart_angle_cmd_pkg::PULSE_MAX,
    parameter int unsigned RESET_ANGLE = 90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] pwm_width,
    output logic        cmd_done,
    output logic        cmd_err
);

    import uart_angle_cmd_pkg::*;

    localparam int unsigned        CNT_W       = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]   MAX_CNT     = CNT_W'(MAX_DIGITS);
    localparam logic [ACC_W-1:0]   ANGLE_LIMIT = ACC_W'(MAX_ANGLE);
    localparam int unsigned        RESET_RAW   = PULSE_MIN + RESET_ANGLE * PULSE_STEP;
    localparam logic [31:0]        RESET_WIDTH = (RESET_RAW > PULSE_MAX) ? PULSE_MAX : RESET_RAW;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        width_q, width_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    byte_class_e        byte_class;
    logic [3:0]         digit;
    logic [31:0]        calc_width;

    assign byte_class = classify_byte(rx_valid, rx_data);
    // Low nibble of '0'..'9' is the digit value
    assign digit      = rx_data[3:0];

    angle_to_width #(
        .PULSE_MIN  (PULSE_MIN),
        .PULSE_STEP (PULSE_STEP),
        .PULSE_MAX  (PULSE_MAX)
    ) u_angle_to_width (
        .angle (acc_q),
        .width (calc_width)
    );

    // Next-state, accumulator and output pulse decode
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            // CALC commits the width and then behaves like IDLE for the byte
            // arriving in the same cycle, so back-to-back commands lose nothing.
            StIdle, StCalc: begin
                if (state_q == StCalc) begin
                    width_d = calc_width;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                case (byte_class)
                    ByteDigit: begin
                        acc_d   = ACC_W'(digit);
                        cnt_d   = CNT_W'(1);
                        state_d = StAccum;
                    end
                    ByteOther: state_d = StDiscard;
                    default: ;
                endcase
            end
            StAccum: begin
                case (byte_class)
                    ByteDigit: begin
                        if (cnt_q < MAX_CNT) begin
                            acc_d = acc_q * ACC_W'(10) + ACC_W'(digit);
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            state_d = StDiscard;
                        end
                    end
                    ByteTerm: begin
                        if (acc_q <= ANGLE_LIMIT) begin
                            state_d = StCalc;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    ByteOther: state_d = StDiscard;
                    default: ;
                endcase
            end
            StDiscard: begin
                if (byte_class == ByteTerm) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset wins over any byte in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            width_q <= RESET_WIDTH;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pwm_width = width_q;
    assign cmd_done  = done_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_angle_cmd.sv
// Self-checking bench for uart_angle_cmd: command table, hand-written corner
// sequences and random command lines checked against a line-level model.
module tb_uart_angle_cmd;

    localparam int unsigned P_MIN   = 8108;
    localparam int unsigned P_STEP  = 330;
    localparam int unsigned P_MAX   = 67567;
    localparam int unsigned ANG_MAX = 180;
    localparam int unsigned DIG_MAX = 3;
    localparam logic [31:0] RESET_W = 32'd37808;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] pwm_width;
    logic        cmd_done;
    logic        cmd_err;

    uart_angle_cmd dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pwm_width (pwm_width),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int err_seen  = 0;

    // Model state: bytes of the current line and a pending done event
    logic [7:0]  line_q[$];
    bit          pend_done = 1'b0;
    logic [31:0] pend_width = '0;
    bit          exp_done = 1'b0;
    bit          exp_err  = 1'b0;
    logic [31:0] exp_width = RESET_W;
    logic [31:0] done_widths[$];

    typedef struct {
        string       text;
        logic [31:0] width;
        int          dones;
        int          errs;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A whole line is judged when its terminator arrives
    function automatic void model_byte(input logic [7:0] b, output bit ev_done,
                                       output bit ev_err, output logic [31:0] ev_width);
        bit ok;
        int val;
        int unsigned w;
        ev_done  = 1'b0;
        ev_err   = 1'b0;
        ev_width = '0;
        if (b == 8'h0d || b == 8'h0a) begin
            if (line_q.size() != 0) begin
                ok  = (line_q.size() <= DIG_MAX);
                val = 0;
                foreach (line_q[i]) begin
                    if (line_q[i] >= 8'h30 && line_q[i] <= 8'h39) begin
                        val = val * 10 + int'(line_q[i] - 8'h30);
                    end else begin
                        ok = 1'b0;
                    end
                end
                if (ok && val <= int'(ANG_MAX)) begin
                    w        = P_MIN + int'(val) * P_STEP;
                    ev_done  = 1'b1;
                    ev_width = (w > P_MAX) ? P_MAX : w;
                end else begin
                    ev_err = 1'b1;
                end
                line_q.delete();
            end
        end else begin
            line_q.push_back(b);
        end
    endfunction

    // Drive one cycle, advance the model, and compare just after the edge
    task automatic step(input bit v, input logic [7:0] d, input bit r);
        bit          ev_done;
        bit          ev_err;
        logic [31:0] ev_width;
        ev_done  = 1'b0;
        ev_err   = 1'b0;
        ev_width = '0;
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        if (!r && v) model_byte(d, ev_done, ev_err, ev_width);
        @(posedge clk);
        #1;
        if (r) begin
            exp_done  = 1'b0;
            exp_err   = 1'b0;
            exp_width = RESET_W;
            pend_done = 1'b0;
            line_q.delete();
        end else begin
            exp_done = pend_done;
            if (pend_done) exp_width = pend_width;
            pend_done  = ev_done;
            pend_width = ev_width;
            exp_err    = ev_err;
        end
        check("cycle_pwm_width", pwm_width, exp_width);
        check("cycle_cmd_done", 32'(cmd_done), 32'(exp_done));
        check("cycle_cmd_err", 32'(cmd_err), 32'(exp_err));
        check("done_err_exclusive", 32'(cmd_done & cmd_err), 32'd0);
        if (cmd_done) begin
            done_seen++;
            done_widths.push_back(pwm_width);
        end
        if (cmd_err) err_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, 8'(s[i]), 1'b0);
    endtask

    initial begin : main
        int          d0;
        int          e0;
        int          kind;
        int          len;
        int          val;
        string       s;
        logic [7:0]  q[$];
        logic [7:0]  b;

        // Reset and quiet state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(3);
        check("reset_pwm_width", pwm_width, 32'd37808);
        check("reset_cmd_done", 32'(cmd_done), 32'd0);
        check("reset_cmd_err", 32'(cmd_err), 32'd0);

        // Command table, applied in order from the reset state
        vecs.push_back('{"181\n",        32'd37808, 0, 1});
        vecs.push_back('{"1234\n",       32'd37808, 0, 1});
        vecs.push_back('{"9x\n",         32'd37808, 0, 1});
        vecs.push_back('{"0\n",          32'd8108,  1, 0});
        vecs.push_back('{"180\015\n",    32'd67508, 1, 0});
        vecs.push_back('{"007\n",        32'd10418, 1, 0});
        vecs.push_back('{"\n",           32'd10418, 0, 0});
        vecs.push_back('{"99\015",       32'd40778, 1, 0});
        vecs.push_back('{"abc\n",        32'd40778, 0, 1});
        vecs.push_back('{"\015\n",       32'd40778, 0, 0});
        vecs.push_back('{"000\015",      32'd8108,  1, 0});
        vecs.push_back('{"0000\n",       32'd8108,  0, 1});
        vecs.push_back('{"x12\n",        32'd8108,  0, 1});
        foreach (vecs[i]) begin
            d0 = done_seen;
            e0 = err_seen;
            send_str(vecs[i].text);
            idle(3);
            check($sformatf("vec%0d_pwm_width", i), pwm_width, vecs[i].width);
            check($sformatf("vec%0d_done_count", i), 32'(done_seen - d0), 32'(vecs[i].dones));
            check($sformatf("vec%0d_err_count", i), 32'(err_seen - e0), 32'(vecs[i].errs));
        end

        // Next command's first byte lands in the CALC cycle
        done_widths.delete();
        d0 = done_seen;
        e0 = err_seen;
        send_str("45\n9\n");
        idle(4);
        check("calc_overlap_done_count", 32'(done_seen - d0), 32'd2);
        check("calc_overlap_err_count", 32'(err_seen - e0), 32'd0);
        if (done_widths.size() == 2) begin
            check("calc_overlap_first_width", done_widths[0], 32'd22958);
            check("calc_overlap_second_width", done_widths[1], 32'd11078);
        end else begin
            check("calc_overlap_width_count", 32'(done_widths.size()), 32'd2);
        end

        // Reset in the middle of a command discards it silently
        d0 = done_seen;
        e0 = err_seen;
        send_str("12");
        step(1'b0, 8'h00, 1'b1);
        check("midreset_pwm_width", pwm_width, 32'd37808);
        send_str("3\n");
        idle(3);
        check("midreset_final_width", pwm_width, 32'd9098);
        check("midreset_done_count", 32'(done_seen - d0), 32'd1);
        check("midreset_err_count", 32'(err_seen - e0), 32'd0);

        // Random command lines against the line-level model
        for (int n = 0; n < 300; n++) begin
            q.delete();
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                val = int'($urandom_range(0, 260));
                s   = $sformatf("%0d", val);
                if ($urandom_range(0, 3) == 0) s = {"0", s};
                for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
            end else if (kind <= 7) begin
                len = int'($urandom_range(1, 5));
                for (int i = 0; i < len; i++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end else if (kind == 8) begin
                len = int'($urandom_range(1, 3));
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h0d || b == 8'h0a) b = 8'h21;
                    q.push_back(b);
                end
            end
            case ($urandom_range(0, 2))
                0:       q.push_back(8'h0d);
                1:       q.push_back(8'h0a);
                default: begin
                    q.push_back(8'h0d);
                    q.push_back(8'h0a);
                end
            endcase
            foreach (q[i]) step(1'b1, q[i], 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
